// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO peripheral: register offsets, pin limits and the
// offset decoder used by the register file.
package gpio_pkg;

  localparam int GPIO_MAX_PINS = 32;

  localparam logic [11:0] GPIO_DO_OFS  = 12'h000;
  localparam logic [11:0] GPIO_OE_OFS  = 12'h004;
  localparam logic [11:0] GPIO_DI_OFS  = 12'h008;
  localparam logic [11:0] GPIO_SET_OFS = 12'h00C;
  localparam logic [11:0] GPIO_CLR_OFS = 12'h010;
  localparam logic [11:0] GPIO_TGL_OFS = 12'h014;

  typedef enum logic [2:0] {
    REG_DO   = 3'd0,
    REG_OE   = 3'd1,
    REG_DI   = 3'd2,
    REG_SET  = 3'd3,
    REG_CLR  = 3'd4,
    REG_TGL  = 3'd5,
    REG_NONE = 3'd7
  } gpio_reg_e;

  // Word index is addr[11:2]; the byte lanes never take part in decoding.
  function automatic gpio_reg_e gpio_decode(input logic [9:0] word);
    gpio_reg_e r;
    case ({word, 2'b00})
      GPIO_DO_OFS:  r = REG_DO;
      GPIO_OE_OFS:  r = REG_OE;
      GPIO_DI_OFS:  r = REG_DI;
      GPIO_SET_OFS: r = REG_SET;
      GPIO_CLR_OFS: r = REG_CLR;
      GPIO_TGL_OFS: r = REG_TGL;
      default:      r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gpio_if.sv
// CPU data-bus command/response bundle for the GPIO peripheral.
// Handshake: the master raises mem_cmd_valid (with sel and the command fields) and holds
// them stable until mem_ready; the slave pulses mem_ready for exactly one cycle per transfer,
// with mem_rdata valid only during that pulse.
interface gpio_if;
  logic        mem_cmd_sel;
  logic        mem_cmd_valid;
  logic        mem_ready;
  logic        mem_cmd_wr;
  logic [11:0] mem_cmd_addr;
  logic [31:0] mem_cmd_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output mem_cmd_sel, mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_cmd_sel, mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/gpio_sync.sv
// Two-stage synchronizer bringing the asynchronous pad inputs into the clk domain.
module gpio_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO peripheral: DO/OE registers, DI readback and SET/CLR/TGL aliases.
// Build option GPIO_SYNC_EN puts a 2-flop synchronizer in front of the pad inputs.
import gpio_pkg::*;

module gpio_ctrl #(
  parameter int NR_GPIOS = 8
) (
  input  logic                clk,
  input  logic                reset_,
  gpio_if.slave               mem,
  output logic [NR_GPIOS-1:0] gpio_oe,
  output logic [NR_GPIOS-1:0] gpio_do,
  input  logic [NR_GPIOS-1:0] gpio_di
);

  logic [NR_GPIOS-1:0] do_q;
  logic [NR_GPIOS-1:0] oe_q;
  logic [NR_GPIOS-1:0] do_nxt;
  logic [NR_GPIOS-1:0] oe_nxt;
  logic [NR_GPIOS-1:0] di_s;
  logic [NR_GPIOS-1:0] wpins;
  logic [31:0]         rd_val;
  logic                ready_q;
  logic [31:0]         rdata_q;
  logic                acc;
  gpio_reg_e           reg_sel;

`ifdef GPIO_SYNC_EN
  gpio_sync #(.WIDTH(NR_GPIOS)) u_sync (
    .clk    (clk),
    .reset_ (reset_),
    .d      (gpio_di),
    .q      (di_s)
  );
`else
  assign di_s = gpio_di;
`endif

  // The !ready term forces at least one idle cycle between back-to-back transfers.
  assign acc     = mem.mem_cmd_valid & mem.mem_cmd_sel & ~ready_q;
  assign reg_sel = gpio_decode(mem.mem_cmd_addr[11:2]);
  assign wpins   = mem.mem_cmd_wdata[NR_GPIOS-1:0];

  // Byte-lane bits and write-data bits above the pin count are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{mem.mem_cmd_addr[1:0], mem.mem_cmd_wdata};

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_DO:  rd_val[NR_GPIOS-1:0] = do_q;
      REG_OE:  rd_val[NR_GPIOS-1:0] = oe_q;
      REG_DI:  rd_val[NR_GPIOS-1:0] = di_s;
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    do_nxt = do_q;
    oe_nxt = oe_q;
    case (reg_sel)
      REG_DO:  do_nxt = wpins;
      REG_OE:  oe_nxt = wpins;
      REG_SET: do_nxt = do_q | wpins;
      REG_CLR: do_nxt = do_q & ~wpins;
      REG_TGL: do_nxt = do_q ^ wpins;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      do_q    <= '0;
      oe_q    <= '0;
    end else begin
      ready_q <= acc;
      rdata_q <= (acc && !mem.mem_cmd_wr) ? rd_val : '0;
      if (acc && mem.mem_cmd_wr) begin
        do_q <= do_nxt;
        oe_q <= oe_nxt;
      end
    end
  end

  assign mem.mem_ready = ready_q;
  assign mem.mem_rdata = rdata_q;
  assign gpio_do       = do_q;
  assign gpio_oe       = oe_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: directed register-map cases plus random traffic
// against a register-level reference model, with a queue-based read-data scoreboard.
module tb_gpio_ctrl;

  localparam int          NR   = 8;
  localparam logic [31:0] MASK = 32'h0000_00FF;

  logic          clk = 1'b0;
  logic          reset_;
  logic [NR-1:0] gpio_oe;
  logic [NR-1:0] gpio_do;
  logic [NR-1:0] gpio_di;

  gpio_if mem ();

  gpio_ctrl #(.NR_GPIOS(NR)) dut (
    .clk     (clk),
    .reset_  (reset_),
    .mem     (mem),
    .gpio_oe (gpio_oe),
    .gpio_do (gpio_do),
    .gpio_di (gpio_di)
  );

  // clock / reset
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] exp_q[$];
  logic [31:0] m_do;
  logic [31:0] m_oe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s got=0x%08h exp=0x%08h", name, act, exp);
  endtask

  // reference model: register map semantics at word level
  function automatic logic [31:0] model_read(input logic [11:0] addr);
    case (addr & 12'hFFC)
      12'h000: return m_do;
      12'h004: return m_oe;
      12'h008: return {24'h0, gpio_di} & MASK;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [11:0] addr, input logic [31:0] data);
    case (addr & 12'hFFC)
      12'h000: m_do = data & MASK;
      12'h004: m_oe = data & MASK;
      12'h00C: m_do = (m_do | data) & MASK;
      12'h010: m_do = (m_do & ~data) & MASK;
      12'h014: m_do = (m_do ^ data) & MASK;
      default: ;
    endcase
  endtask

  // driver: one full transfer, bounded wait for mem_ready
  task automatic bus_access(input bit wr, input logic [11:0] addr, input logic [31:0] wdata);
    int waited;
    exp_q.push_back(wr ? 32'h0 : model_read(addr));
    if (wr) model_write(addr, wdata);
    mem.mem_cmd_sel   = 1'b1;
    mem.mem_cmd_valid = 1'b1;
    mem.mem_cmd_wr    = wr;
    mem.mem_cmd_addr  = addr;
    mem.mem_cmd_wdata = wdata;
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!mem.mem_ready && waited < 10);
    if (!mem.mem_ready) begin
      check("ready_timeout", 32'(waited), 32'(-1));
      void'(exp_q.pop_back());
    end
    mem.mem_cmd_sel   = 1'b0;
    mem.mem_cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (mem.mem_ready === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_ready", 32'h1, 32'h0);
      else check("rdata", mem.mem_rdata, exp_q.pop_front());
    end
  end

  logic [11:0] addr_tbl[9] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010,
                               12'h014, 12'h018, 12'h800, 12'hFFC};

  initial begin
    logic [5:0] pat;
    int         cnt;
    reset_            = 1'b1;
    mem.mem_cmd_sel   = 1'b0;
    mem.mem_cmd_valid = 1'b0;
    mem.mem_cmd_wr    = 1'b0;
    mem.mem_cmd_addr  = '0;
    mem.mem_cmd_wdata = '0;
    gpio_di           = '0;
    m_do              = '0;
    m_oe              = '0;
    idle(3);
    reset_ = 1'b0;
    idle(1);

    check("rst_ready", 32'(mem.mem_ready), 32'h0);
    check("rst_rdata", mem.mem_rdata, 32'h0);
    check("rst_do", 32'(gpio_do), 32'h0);
    check("rst_oe", 32'(gpio_oe), 32'h0);
    bus_access(1'b0, 12'h000, 32'h0);
    bus_access(1'b0, 12'h004, 32'h0);

    // basic writes and readback
    bus_access(1'b1, 12'h000, 32'hA5);
    check("do_after_wr", 32'(gpio_do), 32'hA5);
    bus_access(1'b1, 12'h004, 32'hFF);
    check("oe_after_wr", 32'(gpio_oe), 32'hFF);
    bus_access(1'b0, 12'h000, 32'h0);
    bus_access(1'b0, 12'h004, 32'h0);

    // SET/CLR/TGL chain: A5 -> AF -> 2E -> D1
    bus_access(1'b1, 12'h00C, 32'h0A);
    check("do_set", 32'(gpio_do), 32'hAF);
    bus_access(1'b1, 12'h010, 32'h81);
    check("do_clr", 32'(gpio_do), 32'h2E);
    bus_access(1'b1, 12'h014, 32'hFF);
    check("do_tgl", 32'(gpio_do), 32'hD1);
    bus_access(1'b0, 12'h000, 32'h0);
    bus_access(1'b0, 12'h00C, 32'h0);

    // pad input readback
    gpio_di = 8'h3C;
    idle(3);
    bus_access(1'b0, 12'h008, 32'h0);
    check("di_model", model_read(12'h008), 32'h3C);

    // pin-count masking and unmapped offsets
    bus_access(1'b1, 12'h000, 32'hFFFF_FFFF);
    bus_access(1'b0, 12'h000, 32'h0);
    check("do_masked", 32'(gpio_do), 32'hFF);
    bus_access(1'b1, 12'h800, 32'h1234_5678);
    bus_access(1'b0, 12'h800, 32'h0);
    check("unmapped_no_effect", 32'(gpio_do), 32'hFF);

    // valid held for 6 cycles: ready on every second cycle
    idle(1);
    for (int k = 0; k < 3; k++) exp_q.push_back(model_read(12'h000));
    mem.mem_cmd_sel   = 1'b1;
    mem.mem_cmd_valid = 1'b1;
    mem.mem_cmd_wr    = 1'b0;
    mem.mem_cmd_addr  = 12'h000;
    pat = '0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      pat = {pat[4:0], mem.mem_ready};
    end
    mem.mem_cmd_valid = 1'b0;
    mem.mem_cmd_sel   = 1'b0;
    check("ready_pattern", 32'(pat), 32'h2A);

    // sel=0 never acknowledged
    idle(2);
    mem.mem_cmd_valid = 1'b1;
    mem.mem_cmd_wr    = 1'b1;
    mem.mem_cmd_wdata = 32'h0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (mem.mem_ready) cnt++;
    end
    mem.mem_cmd_valid = 1'b0;
    check("nosel_ready", 32'(cnt), 32'h0);
    check("nosel_do", 32'(gpio_do), 32'hFF);

    // random traffic
    for (int n = 0; n < 60; n++) begin
      logic [11:0] a;
      a = addr_tbl[$urandom_range(0, 8)] | 12'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        gpio_di = NR'($urandom);
        idle(3);
      end
      bus_access(1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      check("rand_do", 32'(gpio_do), m_do);
      check("rand_oe", 32'(gpio_oe), m_oe);
    end

    // reset while a ready pulse is in flight
    bus_access(1'b1, 12'h000, 32'h5A);
    bus_access(1'b1, 12'h004, 32'h0F);
    idle(1);
    mem.mem_cmd_sel   = 1'b1;
    mem.mem_cmd_valid = 1'b1;
    mem.mem_cmd_wr    = 1'b0;
    mem.mem_cmd_addr  = 12'h000;
    @(posedge clk); #1;
    reset_ = 1'b1;
    #1;
    check("midrst_ready", 32'(mem.mem_ready), 32'h0);
    check("midrst_do", 32'(gpio_do), 32'h0);
    check("midrst_oe", 32'(gpio_oe), 32'h0);
    mem.mem_cmd_sel   = 1'b0;
    mem.mem_cmd_valid = 1'b0;
    m_do = '0;
    m_oe = '0;
    idle(2);
    reset_ = 1'b0;
    idle(1);
    bus_access(1'b0, 12'h000, 32'h0);
    bus_access(1'b0, 12'h004, 32'h0);

    idle(4);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
